branch_predict_unit: RTL

//  Parametrised fetch-stage predictor: direct-mapped, tagged BTB with per-entry saturating counters.

---
 rtl/branch_predict_unit_pkg.sv | 9 +
 rtl/branch_predict_unit_bp_entry_ram.sv | 63 ++++++
 rtl/branch_predict_unit.sv | 99 +++++++++
 3 files changed

// File: rtl/branch_predict_unit_pkg.sv
// branch_predict_unit_pkg: shared types and helpers for the fetch-stage branch predictor.
package branch_predict_unit_pkg;
   typedef enum logic {BP_INIT, BP_READY} bp_state_t;
   function automatic logic [31:0] sat_update(input logic [31:0] ctr, input logic taken, input int unsigned width);
      logic [31:0] max_v;
      max_v = (32'd1 << width) - 32'd1;
      return taken ? ((ctr == max_v) ? ctr : ctr + 32'd1) : ((ctr == 32'd0) ? ctr : ctr - 32'd1);
   endfunction
endpackage

// File: rtl/branch_predict_unit_bp_entry_ram.sv
// bp_entry_ram: unreset valid/tag/target/counter arrays with two async reads, one write and a valid-clear port.
module bp_entry_ram
   import branch_predict_unit_pkg::*;
#(
   parameter int ENTRIES  = 32,
   parameter int TAG_BITS = 8,
   parameter int CTR_BITS = 2,
   parameter int IDX_W    = $clog2(ENTRIES)
) (
   input  logic                clk,
   input  logic [IDX_W-1:0]    rd_a_idx,
   output logic                rd_a_valid,
   output logic [TAG_BITS-1:0] rd_a_tag,
   output logic [31:0]         rd_a_target,
   output logic [CTR_BITS-1:0] rd_a_ctr,
   input  logic [IDX_W-1:0]    rd_b_idx,
   output logic                rd_b_valid,
   output logic [TAG_BITS-1:0] rd_b_tag,
   output logic [31:0]         rd_b_target,
   output logic [CTR_BITS-1:0] rd_b_ctr,
   input  logic                wr_en,
   input  logic [IDX_W-1:0]    wr_idx,
   input  logic [TAG_BITS-1:0] wr_tag,
   input  logic [31:0]         wr_target,
   input  logic [CTR_BITS-1:0] wr_ctr,
   input  logic                clr_en,
   input  logic [IDX_W-1:0]    clr_idx
);
   logic [ENTRIES-1:0]  valid_q, valid_d;
   logic [TAG_BITS-1:0] tag_q [ENTRIES];
   logic [TAG_BITS-1:0] tag_d [ENTRIES];
   logic [31:0]         target_q [ENTRIES];
   logic [31:0]         target_d [ENTRIES];
   logic [CTR_BITS-1:0] ctr_q [ENTRIES];
   logic [CTR_BITS-1:0] ctr_d [ENTRIES];
   always_comb begin
      valid_d  = valid_q;
      tag_d    = tag_q;
      target_d = target_q;
      ctr_d    = ctr_q;
      if (wr_en) begin
         valid_d[wr_idx]  = 1'b1;
         tag_d[wr_idx]    = wr_tag;
         target_d[wr_idx] = wr_target;
         ctr_d[wr_idx]    = wr_ctr;
      end
      if (clr_en) valid_d[clr_idx] = 1'b0;
   end
   always_ff @(posedge clk) begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
   end
   assign rd_a_valid  = valid_q[rd_a_idx];
   assign rd_a_tag    = tag_q[rd_a_idx];
   assign rd_a_target = target_q[rd_a_idx];
   assign rd_a_ctr    = ctr_q[rd_a_idx];
   assign rd_b_valid  = valid_q[rd_b_idx];
   assign rd_b_tag    = tag_q[rd_b_idx];
   assign rd_b_target = target_q[rd_b_idx];
   assign rd_b_ctr    = ctr_q[rd_b_idx];
endmodule

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: tagged direct-mapped BTB with saturating counters and an invalidate sweep.
// Define BP_PERF_CNT_EN to add update/mispredict performance counters.
module branch_predict_unit
   import branch_predict_unit_pkg::*;
#(
   parameter int ENTRIES  = 32,
   parameter int CTR_BITS = 2,
   parameter int TAG_BITS = 8
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        Flush,
   input  logic [31:0] Lookup_PC,
   output logic        Hit,
   output logic        Predict_Taken,
   output logic [31:0] Predict_Target,
   output logic        Busy,
   input  logic        Update_En,
   input  logic [31:0] Update_PC,
   input  logic        Update_Taken,
`ifdef BP_PERF_CNT_EN
   input  logic        Update_Predicted,
   output logic [31:0] Perf_Updates,
   output logic [31:0] Perf_Mispredicts,
`endif
   input  logic [31:0] Update_Target
);
   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TOP   = IDX_W + TAG_BITS + 1;
   bp_state_t           state_q, state_d;
   logic [IDX_W-1:0]    ptr_q, ptr_d;
   logic                rd_a_valid, rd_b_valid, up_hit, apply, wr_en;
   logic [TAG_BITS-1:0] rd_a_tag, rd_b_tag;
   logic [31:0]         rd_a_target, rd_b_target, wr_target;
   logic [CTR_BITS-1:0] rd_a_ctr, rd_b_ctr, ctr_sat, wr_ctr;
   logic                unused_pc;
   assign unused_pc = ^{Lookup_PC[1:0], Lookup_PC[31:TOP+1], Update_PC[1:0], Update_PC[31:TOP+1]};
   always_comb begin
      Busy           = state_q == BP_INIT;
      state_d        = (Flush || (Busy && ptr_q != IDX_W'(ENTRIES - 1))) ? BP_INIT : BP_READY;
      ptr_d          = (Flush || !Busy) ? '0 : ptr_q + IDX_W'(1);
      Hit            = !Busy && rd_a_valid && rd_a_tag == Lookup_PC[TOP:IDX_W+2];
      Predict_Taken  = Hit && rd_a_ctr[CTR_BITS-1];
      Predict_Target = Hit ? rd_a_target : '0;
      up_hit         = rd_b_valid && rd_b_tag == Update_PC[TOP:IDX_W+2];
      apply          = !Busy && Update_En && !Flush;
      ctr_sat        = CTR_BITS'(sat_update(32'(rd_b_ctr), Update_Taken, CTR_BITS));
      wr_en          = apply && (up_hit || Update_Taken);
      wr_ctr         = up_hit ? ctr_sat : CTR_BITS'(1 << (CTR_BITS - 1));
      wr_target      = (up_hit && !Update_Taken) ? rd_b_target : Update_Target;
   end
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= BP_INIT;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end
   bp_entry_ram #(.ENTRIES(ENTRIES), .TAG_BITS(TAG_BITS), .CTR_BITS(CTR_BITS), .IDX_W(IDX_W)) u_ram (
      .clk         (CLK),
      .rd_a_idx    (Lookup_PC[IDX_W+1:2]),
      .rd_a_valid  (rd_a_valid),
      .rd_a_tag    (rd_a_tag),
      .rd_a_target (rd_a_target),
      .rd_a_ctr    (rd_a_ctr),
      .rd_b_idx    (Update_PC[IDX_W+1:2]),
      .rd_b_valid  (rd_b_valid),
      .rd_b_tag    (rd_b_tag),
      .rd_b_target (rd_b_target),
      .rd_b_ctr    (rd_b_ctr),
      .wr_en       (wr_en),
      .wr_idx      (Update_PC[IDX_W+1:2]),
      .wr_tag      (Update_PC[TOP:IDX_W+2]),
      .wr_target   (wr_target),
      .wr_ctr      (wr_ctr),
      .clr_en      (Busy),
      .clr_idx     (ptr_q)
   );
`ifdef BP_PERF_CNT_EN
   logic [31:0] upd_cnt_q, upd_cnt_d, mis_cnt_q, mis_cnt_d;
   always_comb begin
      upd_cnt_d = upd_cnt_q + 32'(apply);
      mis_cnt_d = mis_cnt_q + 32'(apply && Update_Predicted != Update_Taken);
   end
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         upd_cnt_q <= '0;
         mis_cnt_q <= '0;
      end else begin
         upd_cnt_q <= upd_cnt_d;
         mis_cnt_q <= mis_cnt_d;
      end
   end
   assign Perf_Updates     = upd_cnt_q;
   assign Perf_Mispredicts = mis_cnt_q;
`endif
endmodule
